acc_out_port: RTL and testbench
===============================

Name: acc_out_port

Overview:
- Output-side reader of the accumulator. Captures the accumulator value and its carry/zero flags whenever the processor executes an OUT instruction.
- Captured values are buffered in a small FIFO and delivered to an external device over a valid/ready handshake.
- Decouples instruction execution from a slow peripheral. Raises a full indication so the control unit can stall OUT instructions.

Parameters:
- DATA_W, 8, accumulator data width
- DEPTH, 4, FIFO entries (power of two, at least 2)
- CNT_W, 3, width of the occupancy count (log2(DEPTH)+1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- out_wr  input  1  OUT strobe from control unit; push request
- in_acc  input  DATA_W  accumulator data value
- in_carry  input  1  accumulator carry flag
- in_zero  input  1  accumulator zero flag
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- count  output  CNT_W  current occupancy
- overflow  output  1  sticky: a push was dropped
- port_data  output  DATA_W  head entry data
- port_flags  output  2  head entry flags, {carry, zero}
- port_valid  output  1  head entry present
- port_ready  input  1  external device accepts the head entry

Behaviour:
- Reset and clocking:
  - One clock domain. All state updates on the rising edge of clk.
  - rst is synchronous and active-high.
  - Reset values: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - After reset: empty=1, full=0, port_valid=0.
  - port_data and port_flags are don't-care while port_valid=0. The bench must not check them then.
  - FIFO storage is not reset.
- Entry format: {in_carry, in_zero, in_acc}, sampled on the push edge.
- Push:
  - Accepted when out_wr=1 and count<DEPTH, evaluated on the registered count at the start of the cycle.
  - Writes the entry at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when port_valid=1 and port_ready=1.
  - rd_ptr increments modulo DEPTH.
- Head outputs (show-ahead):
  - port_valid = (count!=0).
  - port_data and port_flags come from the entry at rd_ptr.
- Latency: a push into an empty FIFO at edge N gives port_valid=1 with that data after edge N, i.e. available in cycle N+1. There is no combinational path from in_acc to port_data.
- Handshake rules:
  - While port_valid=1 and port_ready=0, port_data and port_flags hold stable.
  - port_valid never drops without a pop or a reset.
  - port_ready may be asserted while port_valid=0. It has no effect.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, both pointers advance
  - neither: unchanged
- Full with simultaneous pop: full is evaluated on the pre-edge count. With full=1, out_wr=1 and a pop in the same cycle, the push is dropped, the pop proceeds and count becomes DEPTH-1. This is the required, deterministic behaviour.
- Overflow:
  - Set to 1 when out_wr=1 while full=1.
  - Remains 1 until rst.
  - The dropped data never appears on the port.
- Empty with out_wr=1 and port_ready=1: no pop that cycle, because port_valid=0. The push is accepted and count becomes 1.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Ordering is strictly FIFO across the wrap.
- Flag outputs: full = (count==DEPTH), empty = (count==0). Both are derived from the registered count.
- Reset mid-operation: on rst=1 all pending entries are discarded. In the following cycle port_valid=0 and count=0, even with out_wr=1 in the reset cycle. A push in the reset cycle is ignored.
- The control unit must hold the processor while full=1 and an OUT instruction is pending. The block itself does not stall anything.

Test Plan:
1. Reset then single transfer:
   - Stimulus: rst 2 cycles. out_wr=1 with in_acc=8'hA5, carry=1, zero=0 for 1 cycle. port_ready=1.
   - Required: next cycle port_valid=1, port_data=8'hA5, port_flags=2'b10. The following cycle count=0 and empty=1.
2. Back-pressure hold:
   - Stimulus: push 8'h11, 8'h22. port_ready=0 for 5 cycles, then 1.
   - Required: port_data stays 8'h11 all 5 cycles. Then the port delivers 8'h11 followed by 8'h22 on consecutive cycles.
3. Fill and overflow:
   - Stimulus: port_ready=0. Push 8'h01 through 8'h05.
   - Required: full=1 and count=4 after the 4th push. The 5th push sets overflow=1. Draining yields 01, 02, 03, 04 only. overflow stays 1 until rst.
4. Full with simultaneous pop and push:
   - Stimulus: FIFO holds 8'h10 through 8'h13. Drive out_wr=1 (in_acc=8'h99) and port_ready=1 in the same cycle.
   - Required: count=3, overflow=1. Draining yields 11, 12, 13, with no 99.
5. Streaming across wrap:
   - Stimulus: port_ready=1 and out_wr=1 for 10 consecutive cycles, with in_acc=0 through 9.
   - Required: the port emits 0 through 9 in order, one per cycle starting 1 cycle after the first push. count never exceeds 1. Pointers wrap twice.
6. Reset mid-operation:
   - Stimulus: FIFO holds 3 entries. Assert rst for 1 cycle with out_wr=1.
   - Required: the next cycle shows port_valid=0, count=0, empty=1, overflow=0. A subsequent push of 8'h5A appears first at the port.

Source files
------------

// File: rtl/acc_out_port.sv
// acc_out_port: buffers accumulator snapshots taken on OUT instructions and
// delivers them, oldest first, to a peripheral over a valid/ready handshake.
// The head entry is shown ahead, so data is visible as soon as it is valid.
module acc_out_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] in_acc,
  input  logic              in_carry,
  input  logic              in_zero,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [DATA_W-1:0] port_data,
  output logic [1:0]        port_flags,
  output logic              port_valid,
  input  logic              port_ready
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               overflow_reg, overflow_next;
  logic               push_ok;
  logic               pop_ok;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Status is derived only from the registered count, so a pop in the same
  // cycle never frees room for a push that arrives while full.
  assign full       = (count_reg == DEPTH_C);
  assign empty      = (count_reg == '0);
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign port_valid = !empty;

  assign push_ok  = out_wr && !full;
  assign pop_ok   = port_valid && port_ready;
  assign wr_entry = {in_carry, in_zero, in_acc};

  // Next pointers, occupancy and sticky overflow from this cycle's push/pop.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    if (out_wr && full) begin
      overflow_next = 1'b1;
    end
  end

  // Control state register; a reset discards every pending entry and any
  // push attempted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage is left unreset; each slot captures the snapshot when it is the
  // write target of an accepted push.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Per-slot write enable decoded from the write pointer.
      always_ff @(posedge clk) begin
        if (!rst && push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  // Show-ahead head: the registered slot at rd_ptr drives the port, so there
  // is no combinational path from the accumulator to the peripheral.
  assign head_entry = mem_reg[rd_ptr_reg];
  assign port_data  = head_entry[DATA_W-1:0];
  assign port_flags = head_entry[ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_acc_out_port.sv
// Bench for acc_out_port: a table of hand-derived cycle vectors, a streaming
// sequence across pointer wrap, and random traffic, all backed by a queue
// scoreboard that predicts occupancy, overflow and head ordering.
module tb_acc_out_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       out_wr;
  logic [7:0] in_acc;
  logic       in_carry;
  logic       in_zero;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] port_data;
  logic [1:0] port_flags;
  logic       port_valid;
  logic       port_ready;

  always #5 clk = ~clk;

  acc_out_port #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_wr     (out_wr),
    .in_acc     (in_acc),
    .in_carry   (in_carry),
    .in_zero    (in_zero),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .port_data  (port_data),
    .port_flags (port_flags),
    .port_valid (port_valid),
    .port_ready (port_ready)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       rdy;
    logic [2:0] ecnt;
    logic       evalid;
    logic [9:0] ehead;
    logic       eovf;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb_q[$];
  logic       model_ovf;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic wr, input logic [7:0] acc,
                     input logic c, input logic z, input logic rdy,
                     input logic [2:0] ecnt, input logic evalid,
                     input logic [9:0] ehead, input logic eovf);
    vec_t v;
    v.rst = r; v.wr = wr; v.acc = acc; v.c = c; v.z = z; v.rdy = rdy;
    v.ecnt = ecnt; v.evalid = evalid; v.ehead = ehead; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic wr, input logic [7:0] acc,
                       input logic c, input logic z, input logic rdy);
    rst = r; out_wr = wr; in_acc = acc; in_carry = c; in_zero = z; port_ready = rdy;
  endtask

  // Compare current outputs with the model, then advance the model by the
  // inputs that the coming edge will see.
  task automatic sb_cycle();
    bit was_full;
    was_full = (sb_q.size() == 4);
    chk("sb_count", 32'(count), 32'(sb_q.size()));
    chk("sb_valid", 32'(port_valid), 32'(sb_q.size() != 0));
    chk("sb_full", 32'(full), 32'(was_full));
    chk("sb_empty", 32'(empty), 32'(sb_q.size() == 0));
    chk("sb_overflow", 32'(overflow), 32'(model_ovf));
    if (rst) begin
      sb_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (port_ready && sb_q.size() != 0) begin
        chk("sb_head", 32'({port_flags, port_data}), 32'(sb_q[0]));
        $display("pop flags=%b data=%02h", port_flags, port_data);
        void'(sb_q.pop_front());
      end
      if (out_wr) begin
        if (was_full) model_ovf = 1'b1;
        else sb_q.push_back({in_carry, in_zero, in_acc});
      end
    end
  endtask

  task automatic tick();
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    model_ovf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_valid", 32'(port_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Single transfer.
    add(0, 1, 8'hA5, 1, 0, 1, 3'd0, 0, 10'h000, 0);
    add(0, 0, 8'h00, 0, 0, 1, 3'd1, 1, {2'b10, 8'hA5}, 0);
    add(0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 10'h000, 0);
    // Back-pressure hold.
    add(0, 1, 8'h11, 0, 0, 0, 3'd0, 0, 10'h000, 0);
    add(0, 1, 8'h22, 0, 1, 0, 3'd1, 1, {2'b00, 8'h11}, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 8'h00, 0, 0, 0, 3'd2, 1, {2'b00, 8'h11}, 0);
    add(0, 0, 8'h00, 0, 0, 1, 3'd2, 1, {2'b00, 8'h11}, 0);
    add(0, 0, 8'h00, 0, 0, 1, 3'd1, 1, {2'b01, 8'h22}, 0);
    add(0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 10'h000, 0);
    // Fill and overflow.
    add(0, 1, 8'h01, 0, 1, 0, 3'd0, 0, 10'h000, 0);
    add(0, 1, 8'h02, 1, 1, 0, 3'd1, 1, {2'b01, 8'h01}, 0);
    add(0, 1, 8'h03, 0, 0, 0, 3'd2, 1, {2'b01, 8'h01}, 0);
    add(0, 1, 8'h04, 1, 0, 0, 3'd3, 1, {2'b01, 8'h01}, 0);
    add(0, 1, 8'h05, 1, 1, 0, 3'd4, 1, {2'b01, 8'h01}, 0);
    add(0, 0, 8'h00, 0, 0, 0, 3'd4, 1, {2'b01, 8'h01}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd4, 1, {2'b01, 8'h01}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd3, 1, {2'b11, 8'h02}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd2, 1, {2'b00, 8'h03}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd1, 1, {2'b10, 8'h04}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd0, 0, 10'h000, 1);
    add(1, 0, 8'h00, 0, 0, 1, 3'd0, 0, 10'h000, 1);
    // Full with simultaneous push and pop.
    add(0, 1, 8'h10, 0, 0, 0, 3'd0, 0, 10'h000, 0);
    add(0, 1, 8'h11, 0, 0, 0, 3'd1, 1, {2'b00, 8'h10}, 0);
    add(0, 1, 8'h12, 0, 0, 0, 3'd2, 1, {2'b00, 8'h10}, 0);
    add(0, 1, 8'h13, 0, 0, 0, 3'd3, 1, {2'b00, 8'h10}, 0);
    add(0, 1, 8'h99, 1, 1, 1, 3'd4, 1, {2'b00, 8'h10}, 0);
    add(0, 0, 8'h00, 0, 0, 0, 3'd3, 1, {2'b00, 8'h11}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd3, 1, {2'b00, 8'h11}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd2, 1, {2'b00, 8'h12}, 1);
    add(0, 0, 8'h00, 0, 0, 1, 3'd1, 1, {2'b00, 8'h13}, 1);
    add(0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 10'h000, 1);
    // Reset mid-operation with a push in the reset cycle.
    add(0, 1, 8'h21, 0, 0, 0, 3'd0, 0, 10'h000, 1);
    add(0, 1, 8'h22, 0, 0, 0, 3'd1, 1, {2'b00, 8'h21}, 1);
    add(0, 1, 8'h23, 0, 0, 0, 3'd2, 1, {2'b00, 8'h21}, 1);
    add(1, 1, 8'h77, 1, 1, 0, 3'd3, 1, {2'b00, 8'h21}, 1);
    add(0, 1, 8'h5A, 0, 1, 0, 3'd0, 0, 10'h000, 0);
    add(0, 0, 8'h00, 0, 0, 1, 3'd1, 1, {2'b01, 8'h5A}, 0);
    add(0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 10'h000, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].acc, vecs[i].c, vecs[i].z, vecs[i].rdy);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_valid", i), 32'(port_valid), 32'(vecs[i].evalid));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eovf));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ecnt == 3'd4));
      if (vecs[i].evalid)
        chk($sformatf("vec%0d_head", i), 32'({port_flags, port_data}), 32'(vecs[i].ehead));
      tick();
    end

    // Streaming across pointer wrap: one push and one pop per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'(i), i[0], 1'b0, 1'b1);
      if (i == 0) begin
        chk("stream_valid0", 32'(port_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(port_valid), 32'd1);
        chk("stream_data", 32'(port_data), 32'(i - 1));
      end
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("stream_last_valid", 32'(port_valid), 32'd1);
    chk("stream_last_data", 32'(port_data), 32'd9);
    tick();
    chk("stream_done_empty", 32'(empty), 32'd1);
    chk("stream_done_count", 32'(count), 32'd0);

    // Random traffic against the scoreboard.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0));
      tick();
    end
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk("final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
